// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: geometry functions derived from the RAM address width
// and an operation encoding for occupancy updates. Reused by later FIFO blocks.
package fifo_pkg;

  // Operation seen by the occupancy counter in one cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Number of entries addressed by an aw-bit RAM address.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // Pointer width: address bits plus one wrap bit that separates full from empty.
  function automatic int fifo_ptr_w(input int aw);
    return aw + 1;
  endfunction

  // Ceiling log2, for sizing pointers from a depth rather than an address width.
  function automatic int fifo_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_ram.sv
// Pseudo dual-port RAM: one write port, one registered read port.
// Ports:
//   w_clk, w_addr, w_en, data_in   - write port, written on rising w_clk when w_en
//   r_clk, r_addr, r_en, data_out  - read port, data_out loads mem[r_addr] on rising
//                                    r_clk when r_en and holds otherwise
// Contents and data_out are not reset.
module RAM_DUAL_pseudo #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  w_clk,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_clk,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge w_clk) begin
    if (w_en) mem[w_addr] <= data_in;
  end

  // Read-before-write on a same-address collision; the controller never
  // reads the slot being written in the same cycle.
  always_ff @(posedge r_clk) begin
    if (r_en) data_q <= mem[r_addr];
  end

  assign data_out = data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around RAM_DUAL_pseudo.
// Ports:
//   clk, rst               - rising-edge clock, synchronous active-high reset
//   wr_en, wr_data         - push request and data
//   rd_en                  - pop request
//   rd_data, rd_valid      - popped word, valid the cycle after an accepted pop
//   full, empty            - no free entry / no stored entry
//   almost_full/_empty     - count >= AF_LEVEL / count <= AE_LEVEL
//   count                  - occupancy 0..DEPTH
//   overflow, underflow    - one-cycle pulses for dropped push / dropped pop
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = fifo_ptr_w(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [PTR_W-1:0] AF_LVL = AF_LEVEL[PTR_W-1:0];
  localparam logic [PTR_W-1:0] AE_LVL = AE_LEVEL[PTR_W-1:0];
  localparam logic [PTR_W-1:0] ONE    = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             push_ok;
  logic             pop_ok;
  fifo_op_e         op;

  // Flags depend only on registered state so no input reaches them combinationally.
  // Equal pointers mean empty; equal low bits with differing wrap bits mean full.
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                        (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);

  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + ONE;
    if (pop_ok)  rptr_d = rptr_q + ONE;
    // push_ok excludes full and pop_ok excludes empty, so count stays in 0..DEPTH.
    case (op)
      OP_PUSH: count_d = count_q + ONE;
      OP_POP:  count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_valid_q  <= pop_ok;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Write enable is gated by rst so a push request during reset never lands in the RAM.
  RAM_DUAL_pseudo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .w_clk    (clk),
    .w_addr   (wptr_q[PTR_W-2:0]),
    .w_en     (push_ok & ~rst),
    .data_in  (wr_data),
    .r_clk    (clk),
    .r_addr   (rptr_q[PTR_W-2:0]),
    .r_en     (pop_ok & ~rst),
    .data_out (rd_data)
  );

  // DEPTH is kept for readability of the pointer scheme; tie it into a check-free use.
  logic unused_depth;
  assign unused_depth = (DEPTH == 0);

endmodule
